// File: rtl/mem_access_stage_if.sv
// Bus bundle between the EX/MEM side and the MIPS MEM stage: the MEM-stage
// request inputs, the MEM/WB outputs and the debug memory read port.
interface mem_access_stage_if #(
  parameter int NB_DATA       = 32,
  parameter int NB_REG        = 5,
  parameter int NB_MEM_TO_REG = 2,
  parameter int NB_PC         = 7,
  parameter int NB_DMEM_ADDR  = 5
) ();
  logic                     i_enable;
  logic                     i_mem_read;
  logic                     i_mem_write;
  logic                     i_reg_write;
  logic [1:0]               i_ls_size;
  logic                     i_unsigned;
  logic [NB_DATA-1:0]       i_alu_result;
  logic [NB_DATA-1:0]       i_write_data;
  logic [NB_REG-1:0]        i_write_register;
  logic [NB_PC-1:0]         i_pc;
  logic [NB_DATA-1:0]       i_inm_ext;
  logic [NB_MEM_TO_REG-1:0] i_mem_to_reg;
  logic                     i_halt;
  logic [NB_DMEM_ADDR-1:0]  i_debug_addr;
  logic [NB_DATA-1:0]       o_mem_data;
  logic [NB_DATA-1:0]       o_alu_result;
  logic [NB_PC-1:0]         o_pc;
  logic [NB_DATA-1:0]       o_inm_ext;
  logic [NB_MEM_TO_REG-1:0] o_mem_to_reg;
  logic [NB_REG-1:0]        o_write_register;
  logic                     o_reg_write;
  logic                     o_halt;
  logic                     o_misaligned;
  logic [NB_DATA-1:0]       o_debug_data;

  modport slave (
    input  i_enable, i_mem_read, i_mem_write, i_reg_write, i_ls_size, i_unsigned,
           i_alu_result, i_write_data, i_write_register, i_pc, i_inm_ext,
           i_mem_to_reg, i_halt, i_debug_addr,
    output o_mem_data, o_alu_result, o_pc, o_inm_ext, o_mem_to_reg,
           o_write_register, o_reg_write, o_halt, o_misaligned, o_debug_data
  );

  modport master (
    output i_enable, i_mem_read, i_mem_write, i_reg_write, i_ls_size, i_unsigned,
           i_alu_result, i_write_data, i_write_register, i_pc, i_inm_ext,
           i_mem_to_reg, i_halt, i_debug_addr,
    input  o_mem_data, o_alu_result, o_pc, o_inm_ext, o_mem_to_reg,
           o_write_register, o_reg_write, o_halt, o_misaligned, o_debug_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: 32-word synchronous data memory with byte/half/word
// load-store, the MEM/WB pipeline register and a combinational debug read.
module mem_access_stage #(
  parameter int NB_DATA       = 32,
  parameter int NB_REG        = 5,
  parameter int NB_MEM_TO_REG = 2,
  parameter int NB_PC         = 7,
  parameter int NB_DMEM_ADDR  = 5
) (
  input logic            i_clock,
  input logic            i_reset,
  mem_access_stage_if.slave bus
);
  localparam int NWORDS = 2 ** NB_DMEM_ADDR;

  logic [NB_DATA-1:0]       mem_q [NWORDS];

  logic [NB_DATA-1:0]       rdata_q;
  logic [1:0]               offset_q;
  logic [1:0]               size_q;
  logic                     unsigned_q;
  logic                     mem_read_q;
  logic                     misaligned_q;
  logic [NB_DATA-1:0]       alu_result_q;
  logic [NB_PC-1:0]         pc_q;
  logic [NB_DATA-1:0]       inm_ext_q;
  logic [NB_MEM_TO_REG-1:0] mem_to_reg_q;
  logic [NB_REG-1:0]        write_register_q;
  logic                     reg_write_q;
  logic                     halt_q;

  logic [NB_DMEM_ADDR-1:0]  word_idx;
  logic [1:0]               offset;
  logic                     misaligned;
  logic                     store_en;
  logic [3:0]               byte_en_d;
  logic [NB_DATA-1:0]       wdata_d;
  logic                     misaligned_d;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  // Lane select on the registered word, then sign/zero extension.
  function automatic logic [NB_DATA-1:0] load_extend(input logic [NB_DATA-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [1:0] size,
                                                     input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return {{(NB_DATA-8){~uns & b[7]}}, b};
      2'b01:   return {{(NB_DATA-16){~uns & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign word_idx   = bus.i_alu_result[NB_DMEM_ADDR+1:2];
  assign offset     = bus.i_alu_result[1:0];
  assign misaligned = is_misaligned(bus.i_ls_size, offset);
  assign store_en   = bus.i_enable & bus.i_mem_write & ~misaligned;
  assign misaligned_d = (bus.i_mem_read | bus.i_mem_write) & misaligned;

  always_comb begin
    byte_en_d = 4'b0000;
    wdata_d   = bus.i_write_data;
    case (bus.i_ls_size)
      2'b00: begin
        byte_en_d = 4'b0001 << offset;
        wdata_d   = {4{bus.i_write_data[7:0]}};
      end
      2'b01: begin
        byte_en_d = 4'b0011 << offset;
        wdata_d   = {2{bus.i_write_data[15:0]}};
      end
      default: byte_en_d = 4'b1111;
    endcase
  end

  // Memory write port; reset blocks the clocked write.
  always_ff @(posedge i_clock) begin
    if (!i_reset && store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_d[b]) mem_q[word_idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  // MEM/WB register; the memory read is read-first against the write above.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rdata_q          <= '0;
      offset_q         <= '0;
      size_q           <= '0;
      unsigned_q       <= 1'b0;
      mem_read_q       <= 1'b0;
      misaligned_q     <= 1'b0;
      alu_result_q     <= '0;
      pc_q             <= '0;
      inm_ext_q        <= '0;
      mem_to_reg_q     <= '0;
      write_register_q <= '0;
      reg_write_q      <= 1'b0;
      halt_q           <= 1'b0;
    end else if (bus.i_enable) begin
      rdata_q          <= mem_q[word_idx];
      offset_q         <= offset;
      size_q           <= bus.i_ls_size;
      unsigned_q       <= bus.i_unsigned;
      mem_read_q       <= bus.i_mem_read;
      misaligned_q     <= misaligned_d;
      alu_result_q     <= bus.i_alu_result;
      pc_q             <= bus.i_pc;
      inm_ext_q        <= bus.i_inm_ext;
      mem_to_reg_q     <= bus.i_mem_to_reg;
      write_register_q <= bus.i_write_register;
      reg_write_q      <= bus.i_reg_write;
      halt_q           <= bus.i_halt;
    end
  end

  assign bus.o_mem_data       = (mem_read_q & ~misaligned_q)
                              ? load_extend(rdata_q, offset_q, size_q, unsigned_q) : '0;
  assign bus.o_alu_result     = alu_result_q;
  assign bus.o_pc             = pc_q;
  assign bus.o_inm_ext        = inm_ext_q;
  assign bus.o_mem_to_reg     = mem_to_reg_q;
  assign bus.o_write_register = write_register_q;
  assign bus.o_reg_write      = reg_write_q;
  assign bus.o_halt           = halt_q;
  assign bus.o_misaligned     = misaligned_q;
  assign bus.o_debug_data     = mem_q[bus.i_debug_addr];
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, freeze/reset sequences,
// then random traffic against a byte-array memory model.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.NB_DATA(32), .NB_REG(5), .NB_MEM_TO_REG(2), .NB_PC(7), .NB_DMEM_ADDR(5)) bus ();

  mem_access_stage #(.NB_DATA(32), .NB_REG(5), .NB_MEM_TO_REG(2), .NB_PC(7), .NB_DMEM_ADDR(5)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  model_mem [128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_data, logic exp_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_data = exp_data; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic drive_access(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_mem_read   = rd;
    bus.i_mem_write  = wr;
    bus.i_ls_size    = size;
    bus.i_unsigned   = uns;
    bus.i_alu_result = addr;
    bus.i_write_data = wdata;
  endtask

  function automatic logic [31:0] model_word(int idx);
    return {model_mem[idx*4+3], model_mem[idx*4+2], model_mem[idx*4+1], model_mem[idx*4]};
  endfunction

  initial begin
    logic [31:0] exp_data, exp_alu, val, mask;
    logic        exp_mis;
    logic        rd, wr, uns, en;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    int          n, off, base, dbg;

    bus.i_enable = 1'b1;
    bus.i_reg_write = 1'b0;
    bus.i_write_register = '0;
    bus.i_pc = '0;
    bus.i_inm_ext = '0;
    bus.i_mem_to_reg = '0;
    bus.i_halt = 1'b0;
    bus.i_debug_addr = '0;
    drive_access(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);

    repeat (2) step();
    check("reset_mem_data", bus.o_mem_data, 32'h0);
    check("reset_alu_result", bus.o_alu_result, 32'h0);
    check("reset_misaligned", {31'b0, bus.o_misaligned}, 32'h0);
    rst = 1'b0;

    // Directed table, applied back to back.
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h08, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h09, 32'h0,        32'hFFFFFFBE, 0));
    vecs.push_back(mk(1, 0, 2'b00, 1, 32'h09, 32'h0,        32'h000000BE, 0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h0A, 32'h0,        32'hFFFFDEAD, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0B, 32'hCAFE0011, 32'h0,        0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h08, 32'h0,        32'h11ADBEEF, 0));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0C, 32'h01234567, 32'h0,        0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h0D, 32'h00005555, 32'h0,        1));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h0C, 32'h0,        32'h01234567, 0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h0E, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h08, 32'h0,        32'h0000BEEF, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h88, 32'h0,        32'h11ADBEEF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0B, 32'h0,        32'h00000011, 0));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h10, 32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(mk(1, 1, 2'b11, 0, 32'h10, 32'h0BADC0DE, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0,        32'h0BADC0DE, 0));
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h11, 32'h0,        32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_access(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      bus.i_pc = 7'(i + 3);
      step();
      check($sformatf("vec%0d_mem_data", i), bus.o_mem_data, vecs[i].exp_data);
      check($sformatf("vec%0d_misaligned", i), {31'b0, bus.o_misaligned}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d_pc", i), {25'b0, bus.o_pc}, 32'(i + 3));
    end
    bus.i_debug_addr = 5'd2;
    #1 check("debug_word2", bus.o_debug_data, 32'h11ADBEEF);
    bus.i_debug_addr = 5'd3;
    #1 check("debug_word3_after_misaligned_store", bus.o_debug_data, 32'h01234567);

    // Freeze: registers hold and stores are suppressed.
    drive_access(1'b0, 1'b0, 2'b11, 1'b0, 32'h44, 32'h0);
    bus.i_pc = 7'h33; bus.i_reg_write = 1'b1; bus.i_halt = 1'b1;
    bus.i_inm_ext = 32'hABCD0000; bus.i_mem_to_reg = 2'b01; bus.i_write_register = 5'd7;
    step();
    bus.i_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h08 + 32'(c), 32'hFFFFFFFF);
      bus.i_pc = 7'(c); bus.i_reg_write = 1'b0; bus.i_halt = 1'b0;
      bus.i_inm_ext = 32'(c); bus.i_write_register = 5'(c);
      drive_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h08, 32'hFFFFFFFF);
      step();
      check("freeze_pc", {25'b0, bus.o_pc}, 32'h33);
      check("freeze_halt", {31'b0, bus.o_halt}, 32'h1);
      check("freeze_alu", bus.o_alu_result, 32'h44);
    end
    check("freeze_inm", bus.o_inm_ext, 32'hABCD0000);
    check("freeze_reg_write", {31'b0, bus.o_reg_write}, 32'h1);
    bus.i_debug_addr = 5'd2;
    #1 check("freeze_mem_unchanged", bus.o_debug_data, 32'h11ADBEEF);
    bus.i_enable = 1'b1;
    drive_access(1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    bus.i_pc = 7'h15; bus.i_mem_to_reg = 2'b10; bus.i_write_register = 5'd31;
    step();
    check("resume_pc", {25'b0, bus.o_pc}, 32'h15);
    check("resume_mem_to_reg", {30'b0, bus.o_mem_to_reg}, 32'h2);
    check("resume_write_register", {27'b0, bus.o_write_register}, 32'd31);
    check("resume_halt", {31'b0, bus.o_halt}, 32'h0);

    // Async reset mid-cycle, then held across an edge with a store pending.
    #2 rst = 1'b1;
    #1;
    check("async_reset_pc", {25'b0, bus.o_pc}, 32'h0);
    check("async_reset_wreg", {27'b0, bus.o_write_register}, 32'h0);
    check("async_reset_alu", bus.o_alu_result, 32'h0);
    check("reset_keeps_mem", bus.o_debug_data, 32'h11ADBEEF);
    drive_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h08, 32'h00000000);
    step();
    check("reset_blocks_store", bus.o_debug_data, 32'h11ADBEEF);
    check("reset_held_mem_to_reg", {30'b0, bus.o_mem_to_reg}, 32'h0);
    drive_access(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    // Random traffic against the byte-array model.
    for (int w = 0; w < 32; w++) begin
      wdata = $urandom;
      drive_access(1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), wdata);
      for (int k = 0; k < 4; k++) model_mem[w*4+k] = wdata[8*k +: 8];
      step();
    end
    exp_data = 32'h0; exp_mis = 1'b0; exp_alu = 32'(31 * 4);
    for (int t = 0; t < 400; t++) begin
      rd = 1'($urandom); wr = 1'($urandom); uns = 1'($urandom);
      size = 2'($urandom); addr = $urandom; wdata = $urandom;
      en = ($urandom_range(0, 7) != 0);
      dbg = $urandom_range(0, 31);
      drive_access(rd, wr, size, uns, addr, wdata);
      bus.i_enable = en;
      bus.i_debug_addr = 5'(dbg);
      if (en) begin
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off = int'(addr % 4);
        base = int'((addr % 128) / 4) * 4;
        val = 32'h0;
        for (int k = 0; k < n; k++) val = val | (32'(model_mem[base+off+k]) << (8*k));
        mask = (n == 4) ? 32'h0 : (32'hFFFFFFFF << (8*n));
        if (!uns && n < 4 && val[8*n-1]) val = val | mask;
        exp_mis  = (rd || wr) && ((off % n) != 0);
        exp_data = (rd && (off % n) == 0) ? val : 32'h0;
        exp_alu  = addr;
        if (wr && (off % n) == 0)
          for (int k = 0; k < n; k++) model_mem[base+off+k] = wdata[8*k +: 8];
      end
      step();
      check($sformatf("rand%0d_mem_data", t), bus.o_mem_data, exp_data);
      check($sformatf("rand%0d_misaligned", t), {31'b0, bus.o_misaligned}, {31'b0, exp_mis});
      check($sformatf("rand%0d_alu", t), bus.o_alu_result, exp_alu);
      check($sformatf("rand%0d_debug", t), bus.o_debug_data, model_word(dbg));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage of the MIPS core. Holds the synchronous data memory and performs byte, half and word loads and stores.
- Contains the MEM/WB pipeline register that feeds the write-back stage: load data, ALU result, PC, extended immediate, the mem-to-reg select and the destination register.
- Exposes a combinational debug read port for the debug unit.

Parameters:
- NB_DATA, 32, data/word width
- NB_REG, 5, register-index width
- NB_MEM_TO_REG, 2, write-back select width
- NB_PC, 7, PC width (matches `ADDRWIDTH)
- NB_DMEM_ADDR, 5, word-index width of data memory (32 words)

Ports:
- i_clock  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  pipeline step enable from debug unit; 0 = freeze stage
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_reg_write  in  1  register-file write enable, passed through
- i_ls_size  in  2  access size: 00 byte, 01 half, 11 word; 10 is treated as word
- i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- i_alu_result  in  NB_DATA  byte address / ALU result
- i_write_data  in  NB_DATA  store data, right-aligned
- i_write_register  in  NB_REG  destination register
- i_pc  in  NB_PC  return PC (JAL/JALR)
- i_inm_ext  in  NB_DATA  extended immediate (LUI)
- i_mem_to_reg  in  NB_MEM_TO_REG  write-back select
- i_halt  in  1  HALT marker
- i_debug_addr  in  NB_DMEM_ADDR  debug word index
- o_mem_data  out  NB_DATA  extended load data
- o_alu_result  out  NB_DATA  registered ALU result
- o_pc  out  NB_PC  registered PC
- o_inm_ext  out  NB_DATA  registered immediate
- o_mem_to_reg  out  NB_MEM_TO_REG  registered select
- o_write_register  out  NB_REG  registered destination
- o_reg_write  out  1  registered write enable
- o_halt  out  1  registered HALT marker
- o_misaligned  out  1  registered misaligned-access flag
- o_debug_data  out  NB_DATA  memory word at i_debug_addr

Behaviour:
- Reset is asynchronous and active-high. On i_reset = 1, every MEM/WB register clears to 0, so all outputs except o_debug_data read 0. Memory contents are not cleared; memory is zero at configuration.
- Word index = i_alu_result[NB_DMEM_ADDR+1:2]; byte offset = i_alu_result[1:0]. Upper address bits are ignored, so the address wraps modulo 128 bytes.
- Misalignment is defined as: half access with offset[0] = 1, or word access with offset != 0. Byte accesses are never misaligned.
- Store: on a rising edge with i_enable & i_mem_write & !misaligned, write the selected byte lanes.
  - Byte: i_write_data[7:0] goes to lane offset.
  - Half: i_write_data[15:0] goes to lanes offset+1..offset.
  - Word: all four lanes.
  - Other lanes are unchanged.
- Load: the memory word is read synchronously at the same edge that latches the MEM/WB register. o_mem_data is valid exactly 1 cycle after the request. The extension logic uses the registered offset, size and unsigned flag: select the lane(s), then sign- or zero-extend to NB_DATA.
- Misaligned load: o_mem_data = 0. Misaligned store: memory is unchanged. In both cases o_misaligned = 1 for that instruction's MEM/WB cycle; otherwise o_misaligned = 0.
- When i_mem_read = 0, o_mem_data = 0.
- Read and write to the same word at the same edge: the read returns the old contents (read-first).
- All other outputs are the inputs registered with 1-cycle latency.
- i_enable = 0: all MEM/WB registers hold their values and no store occurs, even if i_mem_write = 1.
- o_halt follows i_halt through the register. The stage itself does not stop.
- o_debug_data is a combinational read of word i_debug_addr and is independent of i_enable and i_reset.
- Reset asserted mid-store: the async clear has priority and the clocked write does not occur while i_reset = 1.

Test Plan:
- Reset: assert i_reset between clock edges → all registered outputs read 0 immediately; memory contents preserved (check via o_debug_data).
- Word store then load: store 0xDEADBEEF at addr 0x08, next cycle load word from 0x08 → o_mem_data = 0xDEADBEEF one cycle after the load; o_debug_data at index 2 = 0xDEADBEEF.
- Sub-word loads from the same word:
  - Byte load, addr 0x09, signed → 0xFFFFFFBE.
  - Byte load, addr 0x09, unsigned → 0x000000BE.
  - Half load, addr 0x0A, signed → 0xFFFFDEAD.
- Byte store: store byte 0x11 at 0x0B → word becomes 0x11ADBEEF; other lanes are unchanged.
- Misaligned accesses:
  - Half store at 0x0D → memory unchanged, o_misaligned = 1 for one cycle.
  - Word load at 0x0E → o_mem_data = 0.
- Freeze: i_enable = 0 with i_mem_write = 1 and changing inputs → outputs hold, memory unchanged. Re-enable → resumes with the next inputs; pass-through of pc = 0x15, mem_to_reg = 10, write_register = 31 appears after 1 cycle.
